rs_ccff_chain_loader: RTL and testbench
=======================================

# rs_ccff_chain_loader

Bitstream loader that sequences an RS_CCFF configuration shift chain. It accepts configuration words over a valid/ready interface and serializes them LSB-first onto the chain head, producing the chain clock-enable consumed by the chain's ICG. It also computes a CRC-16 signature over the bits leaving the chain tail, which represent the previous configuration, so the prior contents can be verified during reload. It sits between the configuration DMA/port and the fabric's CCFF chain.

## Interface
- CHAIN_LEN, 1024, number of CCFFs in the chain (≥1)
- WORD_W, 32, configuration word width (≥2)
- CK  in  1  clock; also the chain clock before the ICG
- RST  in  1  asynchronous, active-high reset
- START  in  1  begin a load; sampled only in IDLE
- ABORT  in  1  cancel the load in progress
- WDATA  in  WORD_W  configuration word; bit 0 is shifted first
- WVALID  in  1  WDATA valid
- WREADY  out  1  loader accepts a word
- CHAIN_D  out  1  data to the chain head CCFF D input
- CHAIN_EN  out  1  chain clock enable to the ICG; the chain shifts on the CK rise that ends a cycle with CHAIN_EN=1
- CHAIN_Q  in  1  chain tail CCFF Q output
- BUSY  out  1  state ≠ IDLE
- DONE  out  1  one-cycle pulse when the load completes
- SIG  out  16  CRC-16 of the tail bits shifted out

## Operation
- States: IDLE, LOAD, SHIFT, FIN.
- IDLE:
  - START=1 → LOAD.
  - On that transition: bit counter cnt=0, crc=0xFFFF.
  - START in any other state is ignored.
- LOAD:
  - WREADY=1.
  - WVALID&WREADY → buf=WDATA, wbits=min(WORD_W, CHAIN_LEN−cnt), go to SHIFT.
- SHIFT:
  - Each cycle: CHAIN_EN=1, CHAIN_D=buf[0], buf>>=1, wbits−−, cnt++.
  - Each cycle: crc=(crc<<1) ^ ((crc[15]^CHAIN_Q) ? 0x1021 : 0).
  - When wbits reaches 0: go to FIN if cnt==CHAIN_LEN, otherwise go to LOAD.
- FIN: DONE=1 for one cycle, then IDLE.
- Last word: unused high bits (the upper WORD_W − (CHAIN_LEN mod WORD_W) bits) are discarded and never shifted.
- Word count per load: ceil(CHAIN_LEN/WORD_W).
- Outside SHIFT: CHAIN_EN=0 and CHAIN_D=0.
- SIG:
  - Mirrors crc.
  - Holds its value after DONE or ABORT until the next START.
- ABORT=1 in LOAD, SHIFT or FIN → IDLE on the next edge.
  - No DONE pulse; a FIN cycle that coincides with ABORT still pulses DONE.
  - A word offered in the same cycle is not accepted (WREADY forced 0).
  - A SHIFT cycle coinciding with ABORT still shifts that one bit.
- ABORT in IDLE has no effect.
- Counter widths: cnt is $clog2(CHAIN_LEN+1) bits; wbits is $clog2(WORD_W+1) bits. Neither counter wraps.

## Timing
- Reset values: state=IDLE, WREADY=0, CHAIN_EN=0, CHAIN_D=0, BUSY=0, DONE=0, SIG=0xFFFF.
- RST asserted mid-load returns the block to IDLE immediately. The chain is left partially shifted, which is legal; software reloads it.
- Word latency: a word accepted at edge k drives its first bit in cycle k+1.
- Back-to-back words: words are taken every WORD_W+1 cycles; there is no prefetch.
- Total load time: CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) + 1 cycles from START to the DONE cycle, with zero WVALID stall.
- CHAIN_EN is asserted in exactly CHAIN_LEN cycles per completed load.
- CHAIN_EN and CHAIN_D are decoded from registered state and buf only, so they are glitch-free at the ICG.
- CHAIN_Q is sampled in the same cycle as CHAIN_EN=1 (the value before the shift edge).

## Structure
- Shared package rs_cfg_pkg holds:
  - the state enum (IDLE/LOAD/SHIFT/FIN)
  - CRC_POLY=16'h1021
  - CRC_INIT=16'hFFFF
  - the default WORD_W
- One sub-module: rs_crc16_serial, a 1-bit-per-cycle CRC with en, init, din and crc ports. It is reused by the readback path.
- The FSM and counters stay in rs_ccff_chain_loader.

## Test plan
- CHAIN_LEN=40, WORD_W=32, words 0xA5A50F0F then 0x000000C3:
  - a 40-stage CCFF chain model holds bits 0xC3A5A50F0F (first-shifted bit at the tail)
  - CHAIN_EN is high 40 cycles
  - DONE pulses once at cycle 43 after START
- CHAIN_LEN=72, WORD_W=8, CHAIN_Q driven with ASCII "123456789", MSB-first per byte → SIG=0x29B1 at DONE.
- WVALID withheld 5 cycles before word 2 → WREADY stays 1, CHAIN_EN=0 during the stall, and the final chain contents are unchanged versus the no-stall run.
- ABORT in the 10th SHIFT cycle → exactly 10 bits shifted, BUSY low next cycle, no DONE, and a subsequent START completes normally.
- RST pulse mid-SHIFT → all outputs at reset values in the same cycle. START during BUSY and ABORT in IDLE are both ignored: cycle counts match the baseline.
- CHAIN_LEN=32, WORD_W=32 (exact fit) and CHAIN_LEN=1 → one word each. CHAIN_EN high for 32 and 1 cycles respectively, with no extra LOAD cycle.

Source files
------------

// File: rtl/rs_cfg_pkg.sv
// Shared types and constants for the RS_CCFF configuration chain loader.
package rs_cfg_pkg;

   localparam int unsigned CRC_W        = 16;
   localparam logic [15:0] CRC_POLY     = 16'h1021;
   localparam logic [15:0] CRC_INIT     = 16'hFFFF;
   localparam int unsigned DEF_WORD_W   = 32;
   localparam int unsigned DEF_CHAIN_LEN = 1024;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   // One MSB-first CRC-16 step with a single input bit.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/rs_crc16_serial.sv
// Bit-serial CRC-16 (poly 0x1021); one input bit per enabled cycle.
module rs_crc16_serial
   import rs_cfg_pkg::*;
(
   input  logic        ck,
   input  logic        rst,
   input  logic        en,
   input  logic        init,
   input  logic        din,
   output logic [15:0] crc
);

   // Signature register: init has priority over accumulation.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         crc <= CRC_INIT;
      end else if (init) begin
         crc <= CRC_INIT;
      end else if (en) begin
         crc <= crc16_step(crc, din);
      end
   end

endmodule

// File: rtl/rs_ccff_chain_loader.sv
// Serializes configuration words LSB-first onto an RS_CCFF chain and
// signs the bits leaving the chain tail with a CRC-16.
module rs_ccff_chain_loader
   import rs_cfg_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
   parameter int unsigned WORD_W    = DEF_WORD_W
)
(
   input  logic              ck,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] wdata,
   input  logic              wvalid,
   output logic              wready,
   output logic              chain_d,
   output logic              chain_en,
   input  logic              chain_q,
   output logic              busy,
   output logic              done,
   output logic [15:0]       sig
);

   localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int unsigned WB_W  = $clog2(WORD_W + 1);

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_nxt;
   logic [CNT_W-1:0]    rem;
   logic [WB_W-1:0]     wbits;
   logic [WB_W-1:0]     wbits_nxt;
   logic [WORD_W-1:0]   sbuf;
   logic [WORD_W-1:0]   sbuf_nxt;
   logic                crc_init;
   logic                crc_en;

   // Bits still owed to the chain; bounds the size of the final word.
   assign rem = CNT_W'(CHAIN_LEN) - cnt;

   // State register.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, counter and word-buffer decode; wready drops with abort.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wbits_nxt = wbits;
      sbuf_nxt  = sbuf;
      crc_init  = 1'b0;
      crc_en    = 1'b0;
      wready    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_LOAD;
               cnt_nxt   = '0;
               crc_init  = 1'b1;
            end
         end
         ST_LOAD: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else begin
               wready = 1'b1;
               if (wvalid) begin
                  sbuf_nxt  = wdata;
                  state_nxt = ST_SHIFT;
                  if (32'(rem) > WORD_W) begin
                     wbits_nxt = WB_W'(WORD_W);
                  end else begin
                     wbits_nxt = WB_W'(rem);
                  end
               end
            end
         end
         ST_SHIFT: begin
            crc_en    = 1'b1;
            sbuf_nxt  = sbuf >> 1;
            wbits_nxt = wbits - WB_W'(1);
            cnt_nxt   = cnt + CNT_W'(1);
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (wbits == WB_W'(1)) begin
               if ((32'(cnt) + 32'd1) == CHAIN_LEN) begin
                  state_nxt = ST_FIN;
               end else begin
                  state_nxt = ST_LOAD;
               end
            end
         end
         ST_FIN: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Counters and shift buffer.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         wbits <= '0;
         sbuf  <= '0;
      end else begin
         cnt   <= cnt_nxt;
         wbits <= wbits_nxt;
         sbuf  <= sbuf_nxt;
      end
   end

   // Chain and status outputs registered from the next state so the ICG
   // enable and head data come straight off flops.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         chain_en <= 1'b0;
         chain_d  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         chain_en <= (state_nxt == ST_SHIFT);
         chain_d  <= (state_nxt == ST_SHIFT) & sbuf_nxt[0];
         busy     <= (state_nxt != ST_IDLE);
         done     <= (state_nxt == ST_FIN);
      end
   end

   // Tail signature: sampled in the shift cycle, before the chain edge.
   rs_crc16_serial u_crc (
      .ck   (ck),
      .rst  (rst),
      .en   (crc_en),
      .init (crc_init),
      .din  (chain_q),
      .crc  (sig)
   );

endmodule

// File: tb/tb_rs_ccff_chain_loader.sv
// Bench for rs_ccff_chain_loader: four configurations side by side, a chain
// model behind each one and a bit/signature scoreboard.
module tb_rs_ccff_chain_loader;

   logic              ck;
   logic              rst;
   logic              abort;
   logic              wvalid;
   logic [31:0]       wdata;
   logic [3:0]        start;
   logic [3:0]        wr;
   logic [3:0]        cd;
   logic [3:0]        ce;
   logic [3:0]        cq;
   logic [3:0]        bsy;
   logic [3:0]        dn;
   logic [3:0][15:0]  sg;

   logic [127:0]      chain [4];
   int                pidx;

   int                n_tests;
   int                n_fail;

   logic              bitq [$];
   logic [15:0]       sigq [$];
   logic [31:0]       words [16];
   int                r_acc [16];
   int                r_en, r_done, r_done_cyc, r_first_en, r_abort_cyc, r_end_cyc, r_words;
   logic [15:0]       r_sig_exp;

   function automatic int len_of(input int i);
      case (i)
         0:       return 40;
         1:       return 72;
         2:       return 32;
         default: return 1;
      endcase
   endfunction

   function automatic int ww_of(input int i);
      return (i == 1) ? 8 : 32;
   endfunction

   // ASCII "123456789", MSB-first per byte.
   function automatic logic pat_bit(input int k);
      logic [7:0] b;
      b = 8'(32'h31 + k / 8);
      return b[7 - (k % 8)];
   endfunction

   // Reference CRC-16/CCITT over bits v[0], v[1], ... v[len-1].
   function automatic logic [15:0] crc_of(input logic [127:0] v, input int len);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int k = 0; k < len; k++) begin
         fb = c[15] ^ v[k];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   rs_ccff_chain_loader #(.CHAIN_LEN(40), .WORD_W(32)) u_a (
      .ck(ck), .rst(rst), .start(start[0]), .abort(abort), .wdata(wdata), .wvalid(wvalid),
      .wready(wr[0]), .chain_d(cd[0]), .chain_en(ce[0]), .chain_q(cq[0]),
      .busy(bsy[0]), .done(dn[0]), .sig(sg[0]));

   rs_ccff_chain_loader #(.CHAIN_LEN(72), .WORD_W(8)) u_b (
      .ck(ck), .rst(rst), .start(start[1]), .abort(abort), .wdata(wdata[7:0]), .wvalid(wvalid),
      .wready(wr[1]), .chain_d(cd[1]), .chain_en(ce[1]), .chain_q(cq[1]),
      .busy(bsy[1]), .done(dn[1]), .sig(sg[1]));

   rs_ccff_chain_loader #(.CHAIN_LEN(32), .WORD_W(32)) u_c (
      .ck(ck), .rst(rst), .start(start[2]), .abort(abort), .wdata(wdata), .wvalid(wvalid),
      .wready(wr[2]), .chain_d(cd[2]), .chain_en(ce[2]), .chain_q(cq[2]),
      .busy(bsy[2]), .done(dn[2]), .sig(sg[2]));

   rs_ccff_chain_loader #(.CHAIN_LEN(1), .WORD_W(32)) u_d (
      .ck(ck), .rst(rst), .start(start[3]), .abort(abort), .wdata(wdata), .wvalid(wvalid),
      .wready(wr[3]), .chain_d(cd[3]), .chain_en(ce[3]), .chain_q(cq[3]),
      .busy(bsy[3]), .done(dn[3]), .sig(sg[3]));

   initial begin
      ck = 1'b0;
      forever #5 ck = ~ck;
   end

   // Chain models: bit 0 is the tail, new bits enter at bit len-1.
   always @(posedge ck or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) chain[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (ce[i]) chain[i] <= (chain[i] >> 1) | (128'(cd[i]) << (len_of(i) - 1));
         end
      end
   end

   // Readback pattern index for the CRC configuration.
   always @(posedge ck or posedge rst) begin
      if (rst) pidx <= 0;
      else if (start[1] && !bsy[1]) pidx <= 0;
      else if (ce[1] && pidx < 71) pidx <= pidx + 1;
   end

   assign cq = {chain[3][0], chain[2][0], pat_bit(pidx), chain[0][0]};

   // Drive one load on instance i; compares every head bit and the signature.
   task automatic run_load(input int i, input int nw, input int stall_at, input int stall_n,
                           input int abort_at, input bit poke_start);
      int   t, widx, pushed, nb, shifts, stall_left;
      bit   fin;
      logic e;
      logic [15:0] es;
      r_en = 0; r_done = 0; r_done_cyc = -1; r_first_en = -1; r_abort_cyc = -1; r_words = 0;
      bitq.delete();
      sigq.delete();
      if (abort_at == 0) begin
         if (i == 1) sigq.push_back(16'h29B1);
         else        sigq.push_back(crc_of(chain[i], len_of(i)));
      end
      start[i] = 1'b1;
      @(negedge ck);
      t = 1; widx = 0; pushed = 0; shifts = 0; stall_left = stall_n; fin = 1'b0;
      while (!fin && t <= 3000) begin
         start[i] = 1'b0;
         abort    = 1'b0;
         wvalid   = 1'b0;
         if (ce[i]) begin
            r_en++;
            shifts++;
            if (r_first_en < 0) r_first_en = t;
            n_tests++;
            if (bitq.size() == 0) begin
               n_fail++;
               $display("FAIL head_bit_extra inst%0d cyc%0d: chain_en=1 with no bit expected", i, t);
            end else begin
               e = bitq.pop_front();
               if (cd[i] !== e) begin
                  n_fail++;
                  $display("FAIL head_bit inst%0d cyc%0d: got %b expected %b", i, t, cd[i], e);
               end
            end
            if (shifts == abort_at) begin
               abort = 1'b1;
               r_abort_cyc = t;
            end
         end
         if (dn[i]) begin
            r_done++;
            r_done_cyc = t;
            if (sigq.size() > 0) begin
               es = sigq.pop_front();
               r_sig_exp = es;
               n_tests++;
               if (sg[i] !== es) begin
                  n_fail++;
                  $display("FAIL sig_at_done inst%0d: got %h expected %h", i, sg[i], es);
               end
            end
         end
         if (wr[i] && widx < nw) begin
            if (widx == stall_at && stall_left > 0) begin
               stall_left--;
               n_tests++;
               if (ce[i] !== 1'b0) begin
                  n_fail++;
                  $display("FAIL stall_en inst%0d cyc%0d: got %b expected 0", i, t, ce[i]);
               end
            end else begin
               wvalid = 1'b1;
               wdata  = words[widx];
               nb = ww_of(i);
               if (len_of(i) - pushed < nb) nb = len_of(i) - pushed;
               for (int b = 0; b < nb; b++) bitq.push_back(words[widx][b]);
               pushed += nb;
               r_acc[widx] = t;
               widx++;
               r_words++;
            end
         end
         if (poke_start && t == 5) start[i] = 1'b1;
         if (!bsy[i]) begin
            fin = 1'b1;
         end else begin
            @(negedge ck);
            t++;
         end
      end
      if (!fin) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout inst%0d: busy still %b after %0d cycles", i, bsy[i], t);
      end
      r_end_cyc = t;
      start[i] = 1'b0;
      abort    = 1'b0;
      wvalid   = 1'b0;
      if (abort_at == 0 && bitq.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL bits_left inst%0d: got %0d unshifted expected 0", i, bitq.size());
      end
      bitq.delete();
      sigq.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge ck);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if ({wr[i], ce[i], cd[i], bsy[i], dn[i], sg[i]} !== {5'b0, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL reset_outputs inst%0d: got %b_%h expected 00000_ffff", i,
                     {wr[i], ce[i], cd[i], bsy[i], dn[i]}, sg[i]);
         end
      end
      rst = 1'b0;
      @(negedge ck);
      n_tests++;
      if ({bsy, dn, ce} !== 12'h000) begin
         n_fail++;
         $display("FAIL idle_after_reset: got %h expected 000", {bsy, dn, ce});
      end
   endtask

   task automatic test_basic();
      for (int pass = 0; pass < 2; pass++) begin
         words[0] = 32'hA5A50F0F;
         words[1] = 32'h000000C3;
         run_load(0, 2, -1, 0, 0, 1'b0);
         n_tests++;
         if (r_en !== 40) begin n_fail++; $display("FAIL basic_en_cycles: got %0d expected 40", r_en); end
         n_tests++;
         if (r_done !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", r_done); end
         n_tests++;
         if (r_done_cyc !== 43) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 43", r_done_cyc); end
         n_tests++;
         if (r_first_en !== 2) begin n_fail++; $display("FAIL word_latency: got %0d expected 2", r_first_en); end
         n_tests++;
         if (r_acc[1] - r_acc[0] !== 33) begin
            n_fail++;
            $display("FAIL word_spacing: got %0d expected 33", r_acc[1] - r_acc[0]);
         end
         n_tests++;
         if (chain[0][39:0] !== 40'hC3A5A50F0F) begin
            n_fail++;
            $display("FAIL basic_chain: got %h expected c3a5a50f0f", chain[0][39:0]);
         end
      end
      repeat (3) @(negedge ck);
      n_tests++;
      if (sg[0] !== r_sig_exp) begin
         n_fail++;
         $display("FAIL sig_hold_after_done: got %h expected %h", sg[0], r_sig_exp);
      end
   endtask

   task automatic test_crc();
      for (int k = 0; k < 9; k++) words[k] = 32'(8'h3C + 8'(k * 17));
      run_load(1, 9, -1, 0, 0, 1'b0);
      n_tests++;
      if (r_en !== 72) begin n_fail++; $display("FAIL crc_en_cycles: got %0d expected 72", r_en); end
      n_tests++;
      if (r_done_cyc !== 82) begin n_fail++; $display("FAIL crc_done_cycle: got %0d expected 82", r_done_cyc); end
      n_tests++;
      if (sg[1] !== 16'h29B1) begin n_fail++; $display("FAIL crc_check_value: got %h expected 29b1", sg[1]); end
   endtask

   task automatic test_stall();
      words[0] = 32'hA5A50F0F;
      words[1] = 32'h000000C3;
      run_load(0, 2, 1, 5, 0, 1'b0);
      n_tests++;
      if (r_en !== 40) begin n_fail++; $display("FAIL stall_en_cycles: got %0d expected 40", r_en); end
      n_tests++;
      if (r_done_cyc !== 48) begin n_fail++; $display("FAIL stall_done_cycle: got %0d expected 48", r_done_cyc); end
      n_tests++;
      if (r_acc[1] - r_acc[0] !== 38) begin
         n_fail++;
         $display("FAIL stall_word_gap: got %0d expected 38", r_acc[1] - r_acc[0]);
      end
      n_tests++;
      if (chain[0][39:0] !== 40'hC3A5A50F0F) begin
         n_fail++;
         $display("FAIL stall_chain: got %h expected c3a5a50f0f", chain[0][39:0]);
      end
   endtask

   task automatic test_abort();
      logic [39:0] prev;
      logic [39:0] exp;
      prev = chain[0][39:0];
      words[0] = 32'h12345678;
      words[1] = 32'h000000FF;
      exp = (prev >> 10) | (40'(words[0][9:0]) << 30);
      run_load(0, 2, -1, 0, 10, 1'b0);
      n_tests++;
      if (r_en !== 10) begin n_fail++; $display("FAIL abort_bits: got %0d expected 10", r_en); end
      n_tests++;
      if (r_done !== 0) begin n_fail++; $display("FAIL abort_done: got %0d expected 0", r_done); end
      n_tests++;
      if (r_end_cyc !== r_abort_cyc + 1) begin
         n_fail++;
         $display("FAIL abort_busy_drop: got %0d expected %0d", r_end_cyc, r_abort_cyc + 1);
      end
      n_tests++;
      if (chain[0][39:0] !== exp) begin
         n_fail++;
         $display("FAIL abort_chain: got %h expected %h", chain[0][39:0], exp);
      end
      n_tests++;
      if (sg[0] !== crc_of(128'(prev), 10)) begin
         n_fail++;
         $display("FAIL abort_sig: got %h expected %h", sg[0], crc_of(128'(prev), 10));
      end
      words[0] = 32'hA5A50F0F;
      words[1] = 32'h000000C3;
      run_load(0, 2, -1, 0, 0, 1'b0);
      n_tests++;
      if (r_done_cyc !== 43) begin n_fail++; $display("FAIL reload_done_cycle: got %0d expected 43", r_done_cyc); end
      n_tests++;
      if (chain[0][39:0] !== 40'hC3A5A50F0F) begin
         n_fail++;
         $display("FAIL reload_chain: got %h expected c3a5a50f0f", chain[0][39:0]);
      end
   endtask

   task automatic test_rst_mid();
      int k;
      start[0] = 1'b1;
      @(negedge ck);
      start[0] = 1'b0;
      k = 0;
      while (!wr[0] && k < 10) begin
         @(negedge ck);
         k++;
      end
      wvalid = 1'b1;
      wdata  = 32'hFFFFFFFF;
      @(negedge ck);
      wvalid = 1'b0;
      repeat (3) @(negedge ck);
      n_tests++;
      if (ce[0] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_shift: got %b expected 1", ce[0]); end
      rst = 1'b1;
      #1;
      n_tests++;
      if ({wr[0], ce[0], cd[0], bsy[0], dn[0], sg[0]} !== {5'b0, 16'hFFFF}) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: got %b_%h expected 00000_ffff",
                  {wr[0], ce[0], cd[0], bsy[0], dn[0]}, sg[0]);
      end
      @(negedge ck);
      rst = 1'b0;
      @(negedge ck);
   endtask

   task automatic test_ignored();
      abort = 1'b1;
      @(negedge ck);
      abort = 1'b0;
      n_tests++;
      if ({bsy[0], wr[0], ce[0]} !== 3'b000) begin
         n_fail++;
         $display("FAIL abort_in_idle: got %b expected 000", {bsy[0], wr[0], ce[0]});
      end
      words[0] = 32'hA5A50F0F;
      words[1] = 32'h000000C3;
      run_load(0, 2, -1, 0, 0, 1'b1);
      n_tests++;
      if (r_en !== 40) begin n_fail++; $display("FAIL ignore_en_cycles: got %0d expected 40", r_en); end
      n_tests++;
      if (r_done_cyc !== 43) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d expected 43", r_done_cyc); end
      n_tests++;
      if (r_end_cyc !== 44) begin n_fail++; $display("FAIL ignore_end_cycle: got %0d expected 44", r_end_cyc); end
      @(negedge ck);
      n_tests++;
      if (bsy[0] !== 1'b0) begin n_fail++; $display("FAIL ignore_no_restart: got %b expected 0", bsy[0]); end
   endtask

   task automatic test_exact_fit();
      words[0] = 32'hDEADBEEF;
      run_load(2, 1, -1, 0, 0, 1'b0);
      n_tests++;
      if (r_en !== 32) begin n_fail++; $display("FAIL exact_en_cycles: got %0d expected 32", r_en); end
      n_tests++;
      if (r_done_cyc !== 34) begin n_fail++; $display("FAIL exact_done_cycle: got %0d expected 34", r_done_cyc); end
      n_tests++;
      if (r_words !== 1) begin n_fail++; $display("FAIL exact_words: got %0d expected 1", r_words); end
      n_tests++;
      if (chain[2][31:0] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL exact_chain: got %h expected deadbeef", chain[2][31:0]);
      end
   endtask

   task automatic test_single();
      logic [31:0] w [2];
      w[0] = 32'h00000001;
      w[1] = 32'hFFFFFFFE;
      for (int pass = 0; pass < 2; pass++) begin
         words[0] = w[pass];
         run_load(3, 1, -1, 0, 0, 1'b0);
         n_tests++;
         if (r_en !== 1) begin n_fail++; $display("FAIL single_en_cycles: got %0d expected 1", r_en); end
         n_tests++;
         if (r_done_cyc !== 3) begin n_fail++; $display("FAIL single_done_cycle: got %0d expected 3", r_done_cyc); end
         n_tests++;
         if (chain[3][0] !== w[pass][0]) begin
            n_fail++;
            $display("FAIL single_chain: got %b expected %b", chain[3][0], w[pass][0]);
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      start   = 4'b0;
      abort   = 1'b0;
      wvalid  = 1'b0;
      wdata   = '0;
      r_sig_exp = 16'hFFFF;
      for (int k = 0; k < 16; k++) begin
         words[k] = '0;
         r_acc[k] = 0;
      end
      @(negedge ck);
      test_reset();
      test_basic();
      test_crc();
      test_stall();
      test_abort();
      test_rst_mid();
      test_ignored();
      test_exact_fit();
      test_single();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
